// File: rtl/mem_access_master.sv
// Data-memory initiator: turns MEM-stage load/store requests into word cycles on the
// data memory, adding byte/halfword access (read-modify-write stores, extending loads).
module mem_access_master #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              WE_DM,
    output logic [ADDR_W-1:0] address1,
    output logic [31:0]       data,
    input  logic [31:0]       Dout
);

    typedef enum logic [2:0] {IDLE, RD, WR, FIN, ERR} state_t;

    state_t      state, state_next;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        bad_req;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Address bits above the memory depth wrap around and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    always_comb begin
        bad_req = 1'b0;
        case (size)
            2'b01:   bad_req = addr[0];
            2'b10:   bad_req = (addr[1:0] != 2'b00);
            2'b11:   bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Word stores skip the read; everything else that is legal reads first.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_req)
                        state_next = ERR;
                    else if (we && size == 2'b10)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = we_q ? WR : FIN;
            WR:      state_next = FIN;
            FIN:     state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_byte = Dout[{lane_q, 3'b000} +: 8];
        sel_half = lane_q[1] ? Dout[31:16] : Dout[15:0];
        load_val = Dout;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{sext_q & sel_half[15]}}, sel_half};
            default: load_val = Dout;
        endcase
        merged = Dout;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (lane_q[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0] = wdata_q[15:0];
    end

    // All memory-side outputs change only here, so they are stable at the memory's negedge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            WE_DM    <= 1'b0;
            rdata    <= '0;
            data     <= '0;
            address1 <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            lane_q   <= 2'b00;
            wdata_q  <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            WE_DM <= 1'b0;
            busy  <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        lane_q  <= addr[1:0];
                        wdata_q <= wdata[15:0];
                        if (bad_req) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            address1 <= addr[ADDR_W+1:2];
                            if (state_next == WR) begin
                                data  <= wdata;
                                WE_DM <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        data  <= merged;
                        WE_DM <= 1'b1;
                    end else begin
                        rdata <= load_val;
                        done  <= 1'b1;
                    end
                end
                WR:      done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
